// File: rtl/rob_retire_unit.sv
// ROB tail-side retire unit: pops the longest done prefix, or drains the ROB during a flush.
// Optional perf counters (stall_cnt, flush_cnt) are built only when ROB_RETIRE_PERF_EN is defined.
package rob_retire_pkg;
  typedef struct packed {
    logic        dn;
    logic [3:0]  tag;
    logic [15:0] val;
  } rob_entry;
endpackage

module rob_retire_lane
  import rob_retire_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  rob_entry dat_i,
  input  logic     rtb_i,
  input  logic     run_i,
  input  logic     drain_i,
  output logic     ret_o,
  output logic     pop_o,
  output logic     ret_v_o,
  output rob_entry ret_dat_o
);
  logic     ret_v_q;
  rob_entry ret_dat_q;

  assign ret_o     = run_i & rtb_i;
  assign pop_o     = rst & (ret_o | drain_i);
  assign ret_v_o   = ret_v_q;
  assign ret_dat_o = ret_dat_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ret_v_q   <= 1'b0;
      ret_dat_q <= '0;
    end else begin
      ret_v_q   <= ret_o;
      ret_dat_q <= ret_o ? dat_i : '0;
    end
  end
endmodule

module rob_retire_unit
  import rob_retire_pkg::*;
#(
  parameter int ROB_LEN   = 16,
  parameter int ROB_TAILS = 1,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  rob_entry [ROB_TAILS-1:0]   rob_dat,
  input  logic [$clog2(ROB_LEN)-1:0] rob_num_occ,
  output logic [ROB_TAILS-1:0]       rob_pop,
  input  logic                       cmt_stall,
  input  logic                       flush,
  output logic                       flush_busy,
  output logic [ROB_TAILS-1:0]       ret_v,
  output rob_entry [ROB_TAILS-1:0]   ret_dat,
  output logic [CNT_W-1:0]           ret_cnt,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [ROB_TAILS-1:0]   rtb, ret_pop;
  logic [CNT_W-1:0]       ret_cnt_q, ret_n;
  logic                   run_en, drain, rob_empty;

  // Full ROB also reads occupancy 0, so true empty needs the head entry to be blank too.
  assign rob_empty  = (rob_num_occ == '0) && (rob_dat[0] == '0);
  assign run_en     = (state_q == RUN) && !cmt_stall && !flush;
  assign drain      = (state_q == FLUSH) && !rob_empty;
  assign flush_busy = (state_q == FLUSH);
  assign ret_cnt    = ret_cnt_q;

  genvar g;
  generate
    for (g = 0; g < ROB_TAILS; g++) begin : g_lane
      if (g == 0) begin : g_head
        assign rtb[g] = rob_dat[g].dn;
      end else begin : g_tail
        assign rtb[g] = rtb[g-1] & rob_dat[g].dn;
      end
      rob_retire_lane u_lane (
        .clk       (clk),
        .rst       (rst),
        .dat_i     (rob_dat[g]),
        .rtb_i     (rtb[g]),
        .run_i     (run_en),
        .drain_i   (drain),
        .ret_o     (ret_pop[g]),
        .pop_o     (rob_pop[g]),
        .ret_v_o   (ret_v[g]),
        .ret_dat_o (ret_dat[g])
      );
    end
  endgenerate

  always_comb begin
    ret_n = '0;
    for (int i = 0; i < ROB_TAILS; i++) ret_n = ret_n + CNT_W'(ret_pop[i]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = FLUSH;
      FLUSH:   if (rob_empty) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ret_cnt_q <= ret_cnt_q + ret_n;
    end
  end

`ifdef ROB_RETIRE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_hit, flush_hit;

  // Any RUN cycle with a present head that does not leave counts as a stall.
  assign stall_hit = (state_q == RUN) && (rob_dat[0] != '0) && !ret_pop[0];
  assign flush_hit = (state_q == RUN) && flush;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_hit && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_hit && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
